// File: rtl/muxkey_pkg.sv
// muxkey_pkg: shared helpers for the muxkey_table lookup multiplexer.
// Holds the per-entry width calculation and the value returned on a miss.
package muxkey_pkg;

  // Bit value replicated across the data width when no entry matches.
  localparam logic MISS_BIT = 1'b0;

  // Width of one packed (key, data) table entry.
  function automatic int entry_width(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

endpackage : muxkey_pkg

// File: rtl/muxkey_entry.sv
// muxkey_entry: compares one packed (key, data) pair against the lookup key.
// Produces a match bit and the entry data gated to zero when it does not match.
module muxkey_entry
  import muxkey_pkg::*;
#(
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN+DATA_LEN-1:0] pair,
  input  logic [KEY_LEN-1:0]          key,
  output logic                        match,
  output logic [DATA_LEN-1:0]         data
);

  localparam int EW = entry_width(KEY_LEN, DATA_LEN);

  logic [KEY_LEN-1:0]  entry_key_s;
  logic [DATA_LEN-1:0] entry_data_s;

  // Key sits in the upper bits of the pair, data in the lower bits.
  assign entry_key_s  = pair[EW-1 -: KEY_LEN];
  assign entry_data_s = pair[DATA_LEN-1:0];
  assign match        = (entry_key_s == key);

  // Pass the entry data only when this entry matches, otherwise the miss value.
  always_comb begin
    if (match) begin
      data = entry_data_s;
    end else begin
      data = {DATA_LEN{MISS_BIT}};
    end
  end

endmodule : muxkey_entry

// File: rtl/muxkey_table.sv
// muxkey_table: parameterised key-value lookup multiplexer.
// Entry j lives at lut[j*(KEY_LEN+DATA_LEN) +: KEY_LEN+DATA_LEN]; on duplicate
// keys the highest-index entry wins, and a miss returns out = 0, hit = 0.
// Compile-time option MUXKEY_OUT_REG_EN: when defined, out/hit are registered
// (one cycle latency, synchronous active-high rst); when undefined (default)
// they are purely combinational and clk/rst are ignored.
module muxkey_table
  import muxkey_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [KEY_LEN-1:0]                    key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
  output logic [DATA_LEN-1:0]                   out,
  output logic                                  hit
);

  localparam int                  EW        = entry_width(KEY_LEN, DATA_LEN);
  localparam logic [DATA_LEN-1:0] MISS_DATA = {DATA_LEN{MISS_BIT}};

  logic [NR_KEY-1:0]   match_s;
  logic [DATA_LEN-1:0] data_s [NR_KEY];
  logic [DATA_LEN-1:0] sel_s;
  logic                hit_s;

  for (genvar j = 0; j < NR_KEY; j++) begin : g_entry
    muxkey_entry #(
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN)
    ) u_entry (
      .pair  (lut[j*EW +: EW]),
      .key   (key),
      .match (match_s[j]),
      .data  (data_s[j])
    );
  end

  assign hit_s = |match_s;

  // Priority select: scan upwards so the highest matching index overwrites lower ones.
  always_comb begin
    sel_s = MISS_DATA;
    for (int j = 0; j < NR_KEY; j++) begin
      if (match_s[j]) begin
        sel_s = data_s[j];
      end else begin
        sel_s = sel_s;
      end
    end
  end

`ifdef MUXKEY_OUT_REG_EN
  logic [DATA_LEN-1:0] out_r;
  logic                hit_r;

  // Output register: reset clears to the miss value, otherwise load this edge's lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= MISS_DATA;
      hit_r <= 1'b0;
    end else begin
      out_r <= sel_s;
      hit_r <= hit_s;
    end
  end

  assign out = out_r;
  assign hit = hit_r;
`else
  // Zero-latency mode: clock and reset do not influence the result.
  logic unused_s;
  assign unused_s = clk ^ rst;

  assign out = sel_s;
  assign hit = hit_s;
`endif

endmodule : muxkey_table

// File: tb/tb_muxkey_table.sv
// tb_muxkey_table: self-checking bench for muxkey_table.
// Works in both builds; MUXKEY_OUT_REG_EN selects the expected timing.
module tb_muxkey_table;

`ifdef MUXKEY_OUT_REG_EN
  localparam bit REG_MODE = 1'b1;
`else
  localparam bit REG_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // width mask table: NR 4, K 2, D 8
  logic [1:0]      key_mask;
  logic [4*10-1:0] lut_mask;
  logic [7:0]      out_mask;
  logic            hit_mask;
  // sparse lane table: NR 4, K 3, D 16
  logic [2:0]      key_sparse;
  logic [4*19-1:0] lut_sparse;
  logic [15:0]     out_sparse;
  logic            hit_sparse;
  // duplicate keys: NR 2, K 3, D 8
  logic [2:0]      key_dup;
  logic [2*11-1:0] lut_dup;
  logic [7:0]      out_dup;
  logic            hit_dup;
  // single entry: NR 1, K 1, D 4
  logic [0:0]      key_single;
  logic [4:0]      lut_single;
  logic [3:0]      out_single;
  logic            hit_single;
  // random table: NR 6, K 3, D 8
  logic [2:0]      key_rand;
  logic [6*11-1:0] lut_rand;
  logic [7:0]      out_rand;
  logic            hit_rand;

  muxkey_table #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u_mask (
    .clk(clk), .rst(rst), .key(key_mask), .lut(lut_mask), .out(out_mask), .hit(hit_mask));
  muxkey_table #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(16)) u_sparse (
    .clk(clk), .rst(rst), .key(key_sparse), .lut(lut_sparse), .out(out_sparse), .hit(hit_sparse));
  muxkey_table #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(8)) u_dup (
    .clk(clk), .rst(rst), .key(key_dup), .lut(lut_dup), .out(out_dup), .hit(hit_dup));
  muxkey_table #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(4)) u_single (
    .clk(clk), .rst(rst), .key(key_single), .lut(lut_single), .out(out_single), .hit(hit_single));
  muxkey_table #(.NR_KEY(6), .KEY_LEN(3), .DATA_LEN(8)) u_rand (
    .clk(clk), .rst(rst), .key(key_rand), .lut(lut_rand), .out(out_rand), .hit(hit_rand));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic [2:0]  key;
    logic [15:0] exp_out;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // advance one rising edge and sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_key(input int dut, input logic [2:0] k);
    case (dut)
      0: key_mask   = k[1:0];
      1: key_sparse = k;
      2: key_dup    = k;
      3: key_single = k[0];
      default: key_rand = k;
    endcase
  endtask

  function automatic logic [31:0] get_out(input int dut);
    case (dut)
      0: return {24'h0, out_mask};
      1: return {16'h0, out_sparse};
      2: return {24'h0, out_dup};
      3: return {28'h0, out_single};
      default: return {24'h0, out_rand};
    endcase
  endfunction

  function automatic logic [31:0] get_hit(input int dut);
    case (dut)
      0: return {31'h0, hit_mask};
      1: return {31'h0, hit_sparse};
      2: return {31'h0, hit_dup};
      3: return {31'h0, hit_single};
      default: return {31'h0, hit_rand};
    endcase
  endfunction

  initial begin
    logic [2:0] rk [6];
    logic [7:0] rd [6];
    logic [7:0] exp_d;
    logic       exp_h;

    rst        = 1'b1;
    lut_mask   = {2'b00, 8'h01, 2'b01, 8'h03, 2'b10, 8'h0f, 2'b11, 8'hff};
    lut_sparse = {3'b000, 16'h1111, 3'b010, 16'h2222, 3'b100, 16'h3333, 3'b110, 16'h4444};
    lut_dup    = {3'b101, 8'hAA, 3'b101, 8'hBB};
    lut_single = {1'b1, 4'h5};
    lut_rand   = '0;
    key_mask   = 2'b00;
    key_sparse = 3'b000;
    key_dup    = 3'b000;
    key_single = 1'b0;
    key_rand   = 3'b000;

    vecs[0]  = '{0, 3'b010, 16'h000f, 1'b1};
    vecs[1]  = '{0, 3'b011, 16'h00ff, 1'b1};
    vecs[2]  = '{0, 3'b000, 16'h0001, 1'b1};
    vecs[3]  = '{0, 3'b001, 16'h0003, 1'b1};
    vecs[4]  = '{1, 3'b100, 16'h3333, 1'b1};
    vecs[5]  = '{1, 3'b011, 16'h0000, 1'b0};
    vecs[6]  = '{1, 3'b000, 16'h1111, 1'b1};
    vecs[7]  = '{1, 3'b110, 16'h4444, 1'b1};
    vecs[8]  = '{1, 3'b111, 16'h0000, 1'b0};
    vecs[9]  = '{2, 3'b101, 16'h00AA, 1'b1};
    vecs[10] = '{2, 3'b000, 16'h0000, 1'b0};
    vecs[11] = '{3, 3'b001, 16'h0005, 1'b1};
    vecs[12] = '{3, 3'b000, 16'h0000, 1'b0};
    vecs[13] = '{1, 3'b010, 16'h2222, 1'b1};
    vecs[14] = '{0, 3'b010, 16'h000f, 1'b1};

    // reset held for two edges: registered outputs clear, combinational ones track
    step();
    step();
    check("reset_out", get_out(1), REG_MODE ? 32'h0 : 32'h1111);
    check("reset_hit", get_hit(1), REG_MODE ? 32'h0 : 32'h1);
    check("reset_out_mask", get_out(0), REG_MODE ? 32'h0 : 32'h01);

    // release reset with key=010: registered result appears only after the next edge
    key_sparse = 3'b010;
    rst        = 1'b0;
    #1;
    check("release_same_cycle_out", get_out(1), REG_MODE ? 32'h0 : 32'h2222);
    check("release_same_cycle_hit", get_hit(1), REG_MODE ? 32'h0 : 32'h1);
    step();
    check("release_next_edge_out", get_out(1), 32'h2222);
    check("release_next_edge_hit", get_hit(1), 32'h1);

    // reset mid-stream for one edge, then recovery on the following edge
    rst = 1'b1;
    step();
    check("midrst_out", get_out(1), REG_MODE ? 32'h0 : 32'h2222);
    check("midrst_hit", get_hit(1), REG_MODE ? 32'h0 : 32'h1);
    rst = 1'b0;
    step();
    check("midrst_recover_out", get_out(1), 32'h2222);
    check("midrst_recover_hit", get_hit(1), 32'h1);

    // table-driven directed vectors
    for (int i = 0; i < 15; i++) begin
      apply_key(vecs[i].dut, vecs[i].key);
      step();
      check($sformatf("vec%0d_out", i), get_out(vecs[i].dut), {16'h0, vecs[i].exp_out});
      check($sformatf("vec%0d_hit", i), get_hit(vecs[i].dut), {31'h0, vecs[i].exp_hit});
    end

    // randomized tables and keys, table and key change every cycle
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < 6; i++) begin
        rk[i] = 3'($urandom_range(7, 0));
        rd[i] = 8'($urandom_range(255, 0));
        lut_rand[(5 - i)*11 +: 11] = {rk[i], rd[i]};
      end
      key_rand = 3'($urandom_range(7, 0));
      // reference: first-listed matching pair wins, nothing listed -> 0
      exp_d = 8'h00;
      exp_h = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (!exp_h && rk[i] == key_rand) begin
          exp_d = rd[i];
          exp_h = 1'b1;
        end
      end
      step();
      check($sformatf("rand%0d_out", it), get_out(4), {24'h0, exp_d});
      check($sformatf("rand%0d_hit", it), get_hit(4), {31'h0, exp_h});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_muxkey_table
